// File: rtl/display_mux.sv
// display_mux: fixed-priority BCD source selector for the front-panel 7-segment digits.
// It keeps the last image lit for a hold time after the enables drop, blinks masked digits,
// and drives registered active-low segment outputs.
module display_mux #(
    parameter int unsigned NUM_SRC     = 2,
    parameter int unsigned NUM_DIGITS  = 6,
    parameter int unsigned BLINK_HALF  = 25_000_000,
    parameter int unsigned HOLD_CYCLES = 0,
    localparam int unsigned SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_SRC-1:0]               src_en,
    input  logic [NUM_SRC*NUM_DIGITS*4-1:0]  src_bcd,
    input  logic [NUM_SRC*NUM_DIGITS-1:0]    src_blink,
    output logic [NUM_DIGITS*7-1:0]          hex,
    output logic                             display_on,
    output logic [SW-1:0]                    active_src,
    output logic                             conflict
);

    localparam int unsigned HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int unsigned BW = $clog2(BLINK_HALF);

    logic [NUM_DIGITS*4-1:0] r_shadow, w_shadow_d;
    logic [NUM_DIGITS-1:0]   r_mask, w_mask_d;
    logic [HW-1:0]           r_hold, w_hold_d;
    logic                    r_disp, w_disp_d;
    logic [SW-1:0]           r_active, w_active_d;
    logic                    r_conflict;
    logic [BW-1:0]           r_blink_cnt;
    logic                    r_phase;
    logic [NUM_DIGITS*7-1:0] r_hex, w_hex_d;

    logic                    w_any;
    logic [SW-1:0]           w_winner;
    logic [3:0]              w_pop;
    logic [NUM_DIGITS*4-1:0] w_sel_bcd;
    logic [NUM_DIGITS-1:0]   w_sel_mask;
    logic                    w_restart;

    function automatic logic [6:0] f_encode(input logic [3:0] bcd);
        case (bcd)
            4'd0:    f_encode = 7'b1000000;
            4'd1:    f_encode = 7'b1111001;
            4'd2:    f_encode = 7'b0100100;
            4'd3:    f_encode = 7'b0110000;
            4'd4:    f_encode = 7'b0011001;
            4'd5:    f_encode = 7'b0010010;
            4'd6:    f_encode = 7'b0000010;
            4'd7:    f_encode = 7'b1111000;
            4'd8:    f_encode = 7'b0000000;
            4'd9:    f_encode = 7'b0010000;
            4'hA:    f_encode = 7'b0111111;
            default: f_encode = 7'b1111111;
        endcase
    endfunction

    // Pick the lowest-index requester and count requesters for conflict detection.
    always_comb begin
        w_winner = '0;
        w_pop    = '0;
        for (int s = int'(NUM_SRC) - 1; s >= 0; s--) begin
            if (src_en[s]) begin
                w_winner = SW'(s);
            end
            w_pop = w_pop + {3'b000, src_en[s]};
        end
        w_any = |src_en;
    end

    // Route the winning source's digits and blink mask.
    always_comb begin
        w_sel_bcd  = src_bcd[NUM_DIGITS*4-1:0];
        w_sel_mask = src_blink[NUM_DIGITS-1:0];
        for (int s = 0; s < int'(NUM_SRC); s++) begin
            if (w_winner == SW'(s)) begin
                w_sel_bcd  = src_bcd[s*NUM_DIGITS*4 +: NUM_DIGITS*4];
                w_sel_mask = src_blink[s*NUM_DIGITS +: NUM_DIGITS];
            end
        end
    end

    // Next image state: latch on any request, otherwise count down the hold time.
    always_comb begin
        w_shadow_d = r_shadow;
        w_mask_d   = r_mask;
        w_active_d = r_active;
        w_hold_d   = r_hold;
        w_disp_d   = r_disp;
        if (w_any) begin
            w_shadow_d = w_sel_bcd;
            w_mask_d   = w_sel_mask;
            w_active_d = w_winner;
            w_hold_d   = HW'(HOLD_CYCLES);
            w_disp_d   = 1'b1;
        end else if (r_hold != '0) begin
            w_hold_d = r_hold - HW'(1);
        end else begin
            w_disp_d = 1'b0;
        end
        // Blink restarts visible when the display lights up or the source changes.
        w_restart = (w_disp_d & ~r_disp) | (w_active_d != r_active);
    end

    // Segment image from the registered state, so hex lags the state by one edge.
    always_comb begin
        w_hex_d = '1;
        for (int d = 0; d < int'(NUM_DIGITS); d++) begin
            if (r_disp && !(r_mask[d] && r_phase)) begin
                w_hex_d[d*7 +: 7] = f_encode(r_shadow[d*4 +: 4]);
            end
        end
    end

    // Image, arbitration and hold registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shadow   <= {NUM_DIGITS{4'hB}};
            r_mask     <= '0;
            r_active   <= '0;
            r_hold     <= '0;
            r_disp     <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_shadow   <= w_shadow_d;
            r_mask     <= w_mask_d;
            r_active   <= w_active_d;
            r_hold     <= w_hold_d;
            r_disp     <= w_disp_d;
            r_conflict <= (w_pop > 4'd1);
        end
    end

    // Blink half-period counter and phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (w_restart) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt == BW'(BLINK_HALF - 1)) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + BW'(1);
        end
    end

    // Registered segment outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hex <= '1;
        end else begin
            r_hex <= w_hex_d;
        end
    end

    assign hex        = r_hex;
    assign display_on = r_disp;
    assign active_src = r_active;
    assign conflict   = r_conflict;

endmodule

// File: tb/tb_display_mux.sv
// tb_display_mux: directed and random stimulus against a cycle-count based reference model.
module tb_display_mux;

    localparam int P_SRC  = 3;
    localparam int P_DIG  = 6;
    localparam int P_BH   = 4;
    localparam int P_HOLD = 3;
    localparam int P_SW   = 2;
    localparam int NEVER  = 1000;

    logic                   clk;
    logic                   rst;
    logic [P_SRC-1:0]       src_en;
    logic [P_SRC*P_DIG*4-1:0] src_bcd;
    logic [P_SRC*P_DIG-1:0] src_blink;
    logic [P_DIG*7-1:0]     hex;
    logic                   display_on;
    logic [P_SW-1:0]        active_src;
    logic                   conflict;

    int n_vec;
    int n_err;

    // Reference model state (as of the most recent edge).
    bit                 m_disp;
    int                 m_active;
    bit                 m_conf;
    bit [3:0]           m_shadow [P_DIG];
    bit [P_DIG-1:0]     m_mask;
    int                 m_since;   // edges since last enable
    int                 m_n;       // edges since last blink restart
    logic [P_DIG*7-1:0] m_hex;

    display_mux #(
        .NUM_SRC     (P_SRC),
        .NUM_DIGITS  (P_DIG),
        .BLINK_HALF  (P_BH),
        .HOLD_CYCLES (P_HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .src_en     (src_en),
        .src_bcd    (src_bcd),
        .src_blink  (src_blink),
        .hex        (hex),
        .display_on (display_on),
        .active_src (active_src),
        .conflict   (conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] seg(input bit [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            4'hA: return 7'b0111111;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic model_reset();
        m_disp   = 1'b0;
        m_active = 0;
        m_conf   = 1'b0;
        for (int d = 0; d < P_DIG; d++) m_shadow[d] = 4'hB;
        m_mask   = '0;
        m_since  = NEVER;
        m_n      = 0;
        m_hex    = '1;
    endtask

    task automatic model_edge();
        bit old_disp;
        int old_act;
        int w;
        bit phase;
        phase = ((m_n / P_BH) % 2) == 1;
        for (int d = 0; d < P_DIG; d++) begin
            if (!m_disp || (m_mask[d] && phase)) m_hex[d*7 +: 7] = 7'b1111111;
            else m_hex[d*7 +: 7] = seg(m_shadow[d]);
        end
        old_disp = m_disp;
        old_act  = m_active;
        if (src_en != '0) begin
            w = -1;
            for (int s = P_SRC - 1; s >= 0; s--) if (src_en[s]) w = s;
            m_active = w;
            m_since  = 0;
            for (int d = 0; d < P_DIG; d++) begin
                m_shadow[d] = src_bcd[(w*P_DIG+d)*4 +: 4];
                m_mask[d]   = src_blink[w*P_DIG+d];
            end
        end else if (m_since < NEVER) begin
            m_since++;
        end
        m_disp = (m_since <= P_HOLD);
        m_conf = ($countones(src_en) > 1);
        if ((m_disp && !old_disp) || (m_active != old_act)) m_n = 0;
        else m_n++;
    endtask

    task automatic check(input string tag);
        n_vec++;
        assert (hex === m_hex) else begin
            n_err++;
            $error("FAIL %s hex: got %h expected %h", tag, hex, m_hex);
        end
        n_vec++;
        assert (display_on === m_disp) else begin
            n_err++;
            $error("FAIL %s display_on: got %b expected %b", tag, display_on, m_disp);
        end
        n_vec++;
        assert (active_src === P_SW'(m_active)) else begin
            n_err++;
            $error("FAIL %s active_src: got %0d expected %0d", tag, active_src, m_active);
        end
        n_vec++;
        assert (conflict === m_conf) else begin
            n_err++;
            $error("FAIL %s conflict: got %b expected %b", tag, conflict, m_conf);
        end
    endtask

    task automatic chk_lit(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check(tag);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        // Reset held with random inputs.
        rst       = 1'b0;
        src_en    = 3'($urandom);
        src_bcd   = 72'({$urandom(), $urandom(), $urandom()});
        src_blink = 18'($urandom);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold");
        chk_lit("rst_hex", 64'(hex), 64'(42'h3FF_FFFF_FFFF));
        @(negedge clk);
        rst    = 1'b1;
        src_en = '0;
        repeat (100) step("idle");
        chk_lit("idle_hex", 64'(hex), 64'(42'h3FF_FFFF_FFFF));

        // Single source with digits 1..6.
        src_blink = '0;
        for (int d = 0; d < P_DIG; d++) begin
            src_bcd[d*4 +: 4]         = 4'(d + 1);
            src_bcd[(P_DIG+d)*4 +: 4] = 4'hA;
        end
        src_en = 3'b001;
        step("single_k");
        chk_lit("single_disp", 64'(display_on), 64'd1);
        chk_lit("single_act", 64'(active_src), 64'd0);
        step("single_k1");
        chk_lit("single_d0", 64'(hex[6:0]), 64'(7'b1111001));
        chk_lit("single_d5", 64'(hex[41:35]), 64'(7'b0000010));

        // Priority between two requesters.
        src_en = 3'b011;
        step("prio");
        chk_lit("prio_conf", 64'(conflict), 64'd1);
        chk_lit("prio_act", 64'(active_src), 64'd0);
        step("prio2");
        src_en = 3'b010;
        step("prio_drop");
        chk_lit("drop_act", 64'(active_src), 64'd1);
        chk_lit("drop_conf", 64'(conflict), 64'd0);
        step("prio_drop2");
        chk_lit("dash_hex", 64'(hex), 64'({6{7'b0111111}}));

        // Hold after a single-cycle enable.
        src_en = '0;
        repeat (8) step("dark");
        chk_lit("dark_disp", 64'(display_on), 64'd0);
        src_en = 3'b001;
        step("hold_k");
        src_en = '0;
        for (int i = 0; i < P_HOLD; i++) begin
            step("hold_run");
            chk_lit("hold_on", 64'(display_on), 64'd1);
        end
        step("hold_end");
        chk_lit("hold_off", 64'(display_on), 64'd0);
        step("hold_blank");
        chk_lit("hold_hex", 64'(hex), 64'(42'h3FF_FFFF_FFFF));
        // Re-enable during the hold.
        src_en = 3'b001;
        step("rehold_k");
        src_en = '0;
        repeat (2) step("rehold_mid");
        src_en = 3'b001;
        step("rehold_again");
        src_en = '0;
        repeat (6) step("rehold_tail");

        // Blink digit 2 of source 0, then switch to a blinking source 1.
        src_bcd[2*4 +: 4]         = 4'd7;
        src_blink                 = '0;
        src_blink[2]              = 1'b1;
        src_blink[P_DIG+2]        = 1'b1;
        src_en = 3'b001;
        repeat (20) step("blink");
        src_en = 3'b010;
        repeat (12) step("blink_sw");
        src_en = 3'b001;
        repeat (6) step("blink_back");

        // Reset while blanked and holding.
        for (int i = 0; i < 2*P_BH && ((m_n / P_BH) % 2) == 0; i++) step("seek_blank");
        src_en = '0;
        step("pre_rst");
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("mid_rst");
        chk_lit("mid_rst_hex", 64'(hex), 64'(42'h3FF_FFFF_FFFF));
        #2;
        rst = 1'b1;
        repeat (10) step("post_rst");
        chk_lit("post_rst_hex", 64'(hex), 64'(42'h3FF_FFFF_FFFF));

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            src_en = ($urandom_range(0, 9) < 4) ? 3'b000 : 3'($urandom);
            if ($urandom_range(0, 2) == 0) src_bcd = 72'({$urandom(), $urandom(), $urandom()});
            if ($urandom_range(0, 4) == 0) src_blink = 18'($urandom);
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
